// File: rtl/score_pkg.sv
// Shared constants, event encoding and history record for the score_tracker slice.
// Consumed by score_tracker (optional undo history: SCORE_TRACKER_UNDO_EN) and bin2bcd_seq.
package score_pkg;

  localparam logic [2:0] PTS_TD     = 3'd6;
  localparam logic [2:0] PTS_XP     = 3'd1;
  localparam logic [2:0] PTS_2PT    = 3'd2;
  localparam logic [2:0] PTS_FG     = 3'd3;
  localparam logic [2:0] PTS_SAFETY = 3'd2;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_UNDO,
    EV_TD,
    EV_XP,
    EV_2PT,
    EV_FG,
    EV_SAFETY,
    EV_TURNOVER
  } event_t;

  typedef struct packed {
    logic       team;
    logic [2:0] delta;
    logic       prev_possession;
  } hist_rec_t;

  typedef enum logic {
    CVT_IDLE,
    CVT_SHIFT
  } cvt_state_t;

  // Highest-priority strobe wins; everything below it in the same cycle is dropped.
  function automatic event_t pick_event(input logic undo, input logic touchdown,
                                        input logic extra_point, input logic two_point,
                                        input logic field_goal, input logic safety,
                                        input logic turnover);
    event_t ev;
    ev = EV_NONE;
    if (undo)             ev = EV_UNDO;
    else if (touchdown)   ev = EV_TD;
    else if (extra_point) ev = EV_XP;
    else if (two_point)   ev = EV_2PT;
    else if (field_goal)  ev = EV_FG;
    else if (safety)      ev = EV_SAFETY;
    else if (turnover)    ev = EV_TURNOVER;
    return ev;
  endfunction

  function automatic logic [11:0] add3_digits(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    for (int i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to 3-digit BCD converter, one input bit per cycle.
// A start pulse always reloads the converter, aborting any conversion in flight.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [11:0]     bcd,
  output cvt_state_t      state
);

  localparam int CNT_W = $clog2(IN_W + 1);

  logic [IN_W-1:0]  sh;
  logic [11:0]      work;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      adj;
  logic [11:0]      nxt_work;
  logic             last;

  assign adj      = add3_digits(work);
  assign nxt_work = {adj[10:0], sh[IN_W-1]};
  assign last     = (cnt == CNT_W'(IN_W - 1));
  assign busy     = (state == CVT_SHIFT);
  assign done     = busy && last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CVT_IDLE;
      sh    <= '0;
      work  <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else if (start) begin
      state <= CVT_SHIFT;
      sh    <= bin;
      work  <= '0;
      cnt   <= '0;
    end else if (state == CVT_SHIFT) begin
      work <= nxt_work;
      sh   <= sh << 1;
      cnt  <= cnt + 1'b1;
      // Result is published on the same edge that consumes the last input bit.
      if (last) begin
        bcd   <= nxt_work;
        state <= CVT_IDLE;
      end
    end
  end

endmodule

// File: rtl/score_tracker.sv
// Two-team football scoring engine with saturating scores and sequential BCD outputs.
// Define SCORE_TRACKER_UNDO_EN to build the LIFO undo history; otherwise undo is ignored.
module score_tracker
  import score_pkg::*;
#(
  parameter int SCORE_W    = 8,
  parameter int MAX_SCORE  = 199,
  parameter int UNDO_DEPTH = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            touchdown,
  input  logic                            extra_point,
  input  logic                            two_point,
  input  logic                            field_goal,
  input  logic                            safety,
  input  logic                            turnover,
  input  logic                            undo,
  output logic                            possession,
  output logic [SCORE_W-1:0]              score1,
  output logic [SCORE_W-1:0]              score2,
  output logic [11:0]                     score1_bcd,
  output logic [11:0]                     score2_bcd,
  output logic                            bcd_valid,
  output logic [$clog2(UNDO_DEPTH+1)-1:0] hist_count
);

  localparam int CNT_W = $clog2(UNDO_DEPTH + 1);

  event_t             ev;
  logic               undo_req;
  logic               push;
  logic               pop;
  logic               toggle;
  logic               team;
  logic [2:0]         pts;
  logic [SCORE_W-1:0] old;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] sat;
  hist_rec_t          rec_new;
  hist_rec_t          top_rec;
  logic               hist_avail;
  logic [SCORE_W-1:0] nxt_score1;
  logic [SCORE_W-1:0] nxt_score2;
  logic               nxt_pos;
  logic               changed;

  always_comb begin
    ev     = pick_event(undo_req, touchdown, extra_point, two_point,
                        field_goal, safety, turnover);
    pts    = '0;
    team   = possession;
    toggle = 1'b0;
    push   = 1'b0;
    case (ev)
      EV_TD:       begin pts = PTS_TD;  push = 1'b1; end
      EV_XP:       begin pts = PTS_XP;  push = 1'b1; toggle = 1'b1; end
      EV_2PT:      begin pts = PTS_2PT; push = 1'b1; toggle = 1'b1; end
      EV_FG:       begin pts = PTS_FG;  push = 1'b1; toggle = 1'b1; end
      EV_SAFETY:   begin pts = PTS_SAFETY; team = ~possession; push = 1'b1; toggle = 1'b1; end
      EV_TURNOVER: begin push = 1'b1; toggle = 1'b1; end
      default:     ;
    endcase
  end

  // Saturating add; the recorded delta is what was really added, so undo is exact.
  always_comb begin
    old     = team ? score2 : score1;
    sum     = (SCORE_W+1)'(old) + (SCORE_W+1)'(pts);
    sat     = (sum > (SCORE_W+1)'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
    rec_new = '{team: team, delta: 3'(sat - old), prev_possession: possession};
  end

  always_comb begin
    nxt_score1 = score1;
    nxt_score2 = score2;
    nxt_pos    = possession;
    pop        = 1'b0;
    if (push) begin
      if (team) nxt_score2 = sat;
      else      nxt_score1 = sat;
      if (toggle) nxt_pos = ~possession;
    end else if (ev == EV_UNDO && hist_avail) begin
      pop = 1'b1;
      if (top_rec.team) nxt_score2 = score2 - SCORE_W'(top_rec.delta);
      else              nxt_score1 = score1 - SCORE_W'(top_rec.delta);
      nxt_pos = top_rec.prev_possession;
    end
  end

  assign changed = (nxt_score1 != score1) || (nxt_score2 != score2);

  always_ff @(posedge clock) begin
    if (reset) begin
      score1     <= '0;
      score2     <= '0;
      possession <= 1'b0;
    end else begin
      score1     <= nxt_score1;
      score2     <= nxt_score2;
      possession <= nxt_pos;
    end
  end

`ifdef SCORE_TRACKER_UNDO_EN
  localparam int PTR_W = $clog2(UNDO_DEPTH);

  hist_rec_t        hist [UNDO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count;

  assign undo_req   = undo;
  assign top_ptr    = (wr_ptr == '0) ? PTR_W'(UNDO_DEPTH - 1) : wr_ptr - 1'b1;
  assign top_rec    = hist[top_ptr];
  assign hist_avail = (count != '0);
  assign hist_count = count;

  // Circular LIFO: wr_ptr is the next free slot, a full push silently drops the oldest.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < UNDO_DEPTH; i++) hist[i] <= '0;
    end else if (push) begin
      hist[wr_ptr] <= rec_new;
      wr_ptr       <= (wr_ptr == PTR_W'(UNDO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (count != CNT_W'(UNDO_DEPTH)) count <= count + 1'b1;
    end else if (pop) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end
  end
`else
  logic hist_unused;

  assign undo_req    = 1'b0;
  assign top_rec     = '0;
  assign hist_avail  = 1'b0;
  assign hist_count  = '0;
  assign hist_unused = ^{undo, pop, rec_new};
`endif

  logic       busy1, busy2, done1, done2;
  cvt_state_t cvt_state1, cvt_state2;
  logic       cvt_unused;

  bin2bcd_seq #(.IN_W(SCORE_W)) u_bcd1 (
    .clock (clock),
    .reset (reset),
    .start (changed),
    .bin   (nxt_score1),
    .busy  (busy1),
    .done  (done1),
    .bcd   (score1_bcd),
    .state (cvt_state1)
  );

  bin2bcd_seq #(.IN_W(SCORE_W)) u_bcd2 (
    .clock (clock),
    .reset (reset),
    .start (changed),
    .bin   (nxt_score2),
    .busy  (busy2),
    .done  (done2),
    .bcd   (score2_bcd),
    .state (cvt_state2)
  );

  // Both converters always restart together, so idle on both means both outputs are current.
  assign bcd_valid  = !(busy1 || busy2);
  assign cvt_unused = ^{done1, done2, cvt_state1, cvt_state2};

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: directed game scenarios plus randomized strobes against a reference model.
module tb_score_tracker;

  localparam int SCORE_W    = 8;
  localparam int MAX_SCORE  = 199;
  localparam int UNDO_DEPTH = 4;
  localparam int HC_W       = $clog2(UNDO_DEPTH + 1);
`ifdef SCORE_TRACKER_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  localparam logic [6:0] E_UNDO = 7'b1000000;
  localparam logic [6:0] E_TD   = 7'b0100000;
  localparam logic [6:0] E_XP   = 7'b0010000;
  localparam logic [6:0] E_2PT  = 7'b0001000;
  localparam logic [6:0] E_FG   = 7'b0000100;
  localparam logic [6:0] E_SF   = 7'b0000010;
  localparam logic [6:0] E_TO   = 7'b0000001;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic touchdown = 1'b0, extra_point = 1'b0, two_point = 1'b0, field_goal = 1'b0;
  logic safety = 1'b0, turnover = 1'b0, undo = 1'b0;
  logic               possession;
  logic [SCORE_W-1:0] score1, score2;
  logic [11:0]        score1_bcd, score2_bcd;
  logic               bcd_valid;
  logic [HC_W-1:0]    hist_count;

  // ---------------- clock / reset
  always #5 clock = ~clock;

  score_tracker #(.SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE), .UNDO_DEPTH(UNDO_DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .touchdown   (touchdown),
    .extra_point (extra_point),
    .two_point   (two_point),
    .field_goal  (field_goal),
    .safety      (safety),
    .turnover    (turnover),
    .undo        (undo),
    .possession  (possession),
    .score1      (score1),
    .score2      (score2),
    .score1_bcd  (score1_bcd),
    .score2_bcd  (score2_bcd),
    .bcd_valid   (bcd_valid),
    .hist_count  (hist_count)
  );

  // ---------------- reference model
  typedef struct {
    int team;
    int delta;
    int prev;
  } rec_t;

  rec_t hist_q[$];
  int   m_score[2];
  int   m_pos;
  int   since;
  int   m_bcd[2];
  bit   model_ok = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic int to_bcd(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic score_evt(input int team, input int pts, input bit toggle);
    int nv;
    nv = m_score[team] + pts;
    if (nv > MAX_SCORE) nv = MAX_SCORE;
    hist_q.push_back('{team, nv - m_score[team], m_pos});
    if (hist_q.size() > UNDO_DEPTH) void'(hist_q.pop_front());
    m_score[team] = nv;
    if (toggle) m_pos = 1 - m_pos;
  endtask

  // Advances the model with the inputs that the next rising edge will sample.
  task automatic model_step();
    int o1, o2;
    rec_t r;
    if (reset) begin
      m_score[0] = 0; m_score[1] = 0; m_pos = 0;
      hist_q.delete();
      since = SCORE_W; m_bcd[0] = 0; m_bcd[1] = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      o1 = m_score[0];
      o2 = m_score[1];
      if (UNDO_EN && undo) begin
        if (hist_q.size() > 0) begin
          r = hist_q.pop_back();
          m_score[r.team] -= r.delta;
          m_pos = r.prev;
        end
      end
      else if (touchdown)   score_evt(m_pos, 6, 1'b0);
      else if (extra_point) score_evt(m_pos, 1, 1'b1);
      else if (two_point)   score_evt(m_pos, 2, 1'b1);
      else if (field_goal)  score_evt(m_pos, 3, 1'b1);
      else if (safety)      score_evt(1 - m_pos, 2, 1'b1);
      else if (turnover)    score_evt(m_pos, 0, 1'b1);
      if (m_score[0] != o1 || m_score[1] != o2) since = 0;
      else if (since < SCORE_W) begin
        since++;
        if (since == SCORE_W) begin
          m_bcd[0] = to_bcd(m_score[0]);
          m_bcd[1] = to_bcd(m_score[1]);
        end
      end
    end
  endtask

  // ---------------- scoreboard: compare every cycle, then step the model
  initial begin
    forever begin
      @(negedge clock);
      if (model_ok) begin
        check("score1", score1, m_score[0]);
        check("score2", score2, m_score[1]);
        check("possession", possession, m_pos);
        check("hist_count", hist_count, UNDO_EN ? hist_q.size() : 0);
        check("bcd_valid", bcd_valid, (since >= SCORE_W) ? 1 : 0);
        check("score1_bcd", score1_bcd, m_bcd[0]);
        check("score2_bcd", score2_bcd, m_bcd[1]);
      end
      model_step();
    end
  end

  // ---------------- driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic [6:0] ev);
    {undo, touchdown, extra_point, two_point, field_goal, safety, turnover} = ev;
  endtask

  task automatic pulse(input logic [6:0] ev);
    drive(ev);
    tick(1);
    drive('0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // ---------------- directed + random stimulus
  logic [6:0] rev;

  initial begin
    tick(2);
    reset = 1'b0;
    check("rst_score1", score1, 0);
    check("rst_bcd_valid", bcd_valid, 1);
    check("rst_hist", hist_count, 0);

    // touchdown then extra point for team 1
    pulse(E_TD);
    pulse(E_XP);
    check("t1_score1", score1, 7);
    check("t1_pos", possession, 1);
    tick(7);
    check("t1_bcd_not_yet", bcd_valid, 0);
    tick(1);
    check("t1_bcd_valid", bcd_valid, 1);
    check("t1_bcd1", score1_bcd, 'h007);

    // safety credits the defense; simultaneous strobes keep only the highest
    pulse(E_SF);
    check("t2_safety_s1", score1, 9);
    check("t2_safety_pos", possession, 0);
    pulse(E_TD | E_FG);
    check("t2_prio_s1", score1, 15);
    check("t2_prio_pos", possession, 0);

    // saturation at the ceiling and undo of a clipped field goal
    do_reset();
    pulse(E_TO);
    for (int i = 0; i < 32; i++) pulse(E_TD);
    pulse(E_FG);
    pulse(E_TO);
    pulse(E_2PT);
    pulse(E_TO);
    check("t3_pre_s2", score2, 197);
    pulse(E_FG);
    check("t3_sat_s2", score2, 199);
    check("t3_sat_pos", possession, 0);
    pulse(E_UNDO);
    check("t3_undo_s2", score2, UNDO_EN ? 197 : 199);
    check("t3_undo_pos", possession, UNDO_EN ? 1 : 0);

    // history depth overflow and LIFO unwinding
    do_reset();
    pulse(E_TD);
    pulse(E_XP);
    pulse(E_TD);
    pulse(E_FG);
    pulse(E_TD);
    check("t4_hist_full", hist_count, UNDO_EN ? 4 : 0);
    for (int i = 0; i < 5; i++) pulse(E_UNDO);
    check("t4_s1", score1, UNDO_EN ? 6 : 13);
    check("t4_s2", score2, UNDO_EN ? 0 : 9);
    check("t4_pos", possession, 0);
    check("t4_hist_empty", hist_count, 0);

    // frequent score changes keep the converters restarting
    do_reset();
    for (int i = 0; i < 7; i++) begin
      pulse(E_TD);
      tick(2);
    end
    check("t5_busy", bcd_valid, 0);
    tick(8);
    check("t5_valid", bcd_valid, 1);
    check("t5_bcd1", score1_bcd, 'h042);
    check("t5_bcd2", score2_bcd, 'h000);

    // reset in the middle of a conversion
    pulse(E_TD);
    tick(3);
    do_reset();
    check("t6_s1", score1, 0);
    check("t6_pos", possession, 0);
    check("t6_valid", bcd_valid, 1);
    check("t6_bcd1", score1_bcd, 0);
    check("t6_hist", hist_count, 0);

    // randomized play
    for (int c = 0; c < 3000; c++) begin
      rev = '0;
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(0, 99) < ((b == 5) ? 12 : 7)) rev[b] = 1'b1;
      end
      drive(rev);
      reset = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    drive('0);
    reset = 1'b0;
    tick(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
